// File: rtl/ifetch_queue_if.sv
// Bundle between the prefetch queue, the instruction memory port, the redirect source and decode.
// master = the queue itself, slave = the surrounding pipeline/memory.
interface ifetch_queue_if;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        stallD;
    logic        validD;
    logic [31:0] pcD;
    logic [31:0] instrD;

    modport master (
        input  redirect, redirectPc, imemGnt, imemRvalid, imemRdata, stallD,
        output imemReq, imemAddr, validD, pcD, instrD
    );

    modport slave (
        output redirect, redirectPc, imemGnt, imemRvalid, imemRdata, stallD,
        input  imemReq, imemAddr, validD, pcD, instrD
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: sequential fetch, in-order response buffering, flush on redirect.
// Define IFQ_STATS_EN to add the fetchedCnt/flushedCnt statistics outputs.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic           clk,
    input  logic           reset,
    ifetch_queue_if.master bus
`ifdef IFQ_STATS_EN
    ,
    output logic [31:0]    fetchedCnt,
    output logic [31:0]    flushedCnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    cnt_t          count;
    cnt_t          outstanding;
    cnt_t          drop_cnt;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          room;
    logic          accept;
    logic          resp;
    logic          keep;
    logic          pop;
    logic [CW:0]   in_use;
    cnt_t          out_after;

    // Requests are throttled so that every in-flight response is guaranteed a FIFO slot.
    assign in_use      = {1'b0, count} + {1'b0, outstanding};
    assign room        = in_use < DEPTH_C;
    assign bus.imemReq = reset & !bus.redirect & room;
    assign bus.imemAddr = fetch_pc;
    assign accept      = bus.imemReq & bus.imemGnt;
    assign resp        = bus.imemRvalid;
    assign keep        = resp & !bus.redirect & (drop_cnt == '0);
    assign out_after   = outstanding - cnt_t'(resp);

    assign bus.validD  = (count != '0);
    assign pop         = bus.validD & !bus.stallD & !bus.redirect;
    assign bus.pcD     = bus.validD ? pc_mem[rd_ptr]    : 32'h0;
    assign bus.instrD  = bus.validD ? instr_mem[rd_ptr] : 32'h0;

    // Requests still in flight at a redirect belong to the old path and are dropped on return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (bus.redirect) begin
            fetch_pc    <= bus.redirectPc;
            resp_pc     <= bus.redirectPc;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= out_after;
            drop_cnt    <= out_after;
        end else begin
            if (accept)
                fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + cnt_t'(accept) - cnt_t'(resp);
            if (resp && drop_cnt != '0)
                drop_cnt <= drop_cnt - cnt_t'(1);
            if (keep) begin
                wr_ptr  <= wr_ptr + PW'(1);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + cnt_t'(keep) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (keep) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= bus.imemRdata;
        end
    end

`ifdef IFQ_STATS_EN
    logic discard;
    assign discard = resp & !keep;

    // Flushed work = responses thrown away plus entries wiped out of the FIFO by a redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchedCnt <= 32'h0;
            flushedCnt <= 32'h0;
        end else begin
            if (pop)
                fetchedCnt <= fetchedCnt + 32'd1;
            flushedCnt <= flushedCnt + 32'(discard) + (bus.redirect ? 32'(count) : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue against a queue-based model with epoch-tagged memory requests.
// Define IFQ_STATS_EN to also check the statistics counters.
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          ready;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic reset;

    ifetch_queue_if bus();

`ifdef IFQ_STATS_EN
    logic [31:0] fetchedCnt;
    logic [31:0] flushedCnt;
`endif

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef IFQ_STATS_EN
        ,
        .fetchedCnt (fetchedCnt),
        .flushedCnt (flushedCnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc;

    bit          stallIn;
    bit          gntIn;
    bit          redirIn;
    logic [31:0] redirTarget;
    int          latLo;
    int          latHi;
    logic [31:0] dataKey;

    logic [31:0] fetchPcM;
    int          epoch;
    int          lastReady;
    req_t        pend[$];
    ent_t        mq[$];
    logic [31:0] fetchedM;
    logic [31:0] flushedM;
    int          acceptsSeen;
    int          firstValidCyc;
    logic [31:0] firstValidPc;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic doReset();
        reset              = 1'b0;
        bus.redirect       = 1'b0;
        bus.redirectPc     = 32'h0;
        bus.imemGnt        = 1'b0;
        bus.imemRvalid     = 1'b0;
        bus.imemRdata      = 32'h0;
        bus.stallD         = 1'b0;
        #1;
        checkOutput("rstImemReq", 32'(bus.imemReq), 32'd0);
        checkOutput("rstValidD",  32'(bus.validD),  32'd0);
        checkOutput("rstPcD",     bus.pcD,          32'h0);
        checkOutput("rstInstrD",  bus.instrD,       32'h0);
`ifdef IFQ_STATS_EN
        checkOutput("rstFetchedCnt", fetchedCnt, 32'h0);
        checkOutput("rstFlushedCnt", flushedCnt, 32'h0);
`endif
        pend.delete();
        mq.delete();
        fetchPcM      = RESET_PC;
        epoch         = 0;
        lastReady     = -1;
        fetchedM      = 32'h0;
        flushedM      = 32'h0;
        cyc           = 0;
        acceptsSeen   = 0;
        firstValidCyc = -1;
        firstValidPc  = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
    task automatic applyStimulus();
        bit   expReq;
        bit   expValid;
        bit   respNow;
        bit   popNow;
        req_t r;
        ent_t head;
        int   rdy;

        respNow = (pend.size() != 0) && (pend[0].ready <= cyc);
        bus.redirect   = redirIn;
        bus.redirectPc = redirTarget;
        bus.stallD     = stallIn;
        bus.imemGnt    = gntIn;
        bus.imemRvalid = respNow;
        bus.imemRdata  = respNow ? pend[0].data : 32'hDEAD_BEEF;

        @(negedge clk);
        expReq   = !redirIn && (mq.size() + pend.size() < DEPTH);
        expValid = (mq.size() != 0);
        head     = '{pc: 32'h0, instr: 32'h0};
        if (expValid)
            head = mq[0];

        checkOutput("imemReq", 32'(bus.imemReq), 32'(expReq));
        if (expReq)
            checkOutput("imemAddr", bus.imemAddr, fetchPcM);
        checkOutput("validD", 32'(bus.validD), 32'(expValid));
        checkOutput("pcD",    bus.pcD,    head.pc);
        checkOutput("instrD", bus.instrD, head.instr);
`ifdef IFQ_STATS_EN
        checkOutput("fetchedCnt", fetchedCnt, fetchedM);
        checkOutput("flushedCnt", flushedCnt, flushedM);
`endif

        if (bus.validD && firstValidCyc < 0) begin
            firstValidCyc = cyc;
            firstValidPc  = bus.pcD;
        end
        if (bus.imemReq && bus.imemGnt)
            acceptsSeen++;

        popNow = expValid && !stallIn && !redirIn;
        if (popNow) begin
            void'(mq.pop_front());
            fetchedM++;
        end
        if (respNow) begin
            r = pend.pop_front();
            if (!redirIn && r.epoch == epoch)
                mq.push_back('{pc: r.addr, instr: r.data});
            else
                flushedM++;
        end
        if (expReq && gntIn) begin
            rdy = cyc + int'($urandom_range(latHi, latLo));
            if (rdy <= lastReady)
                rdy = lastReady + 1;
            lastReady = rdy;
            pend.push_back('{addr: fetchPcM, data: fetchPcM ^ dataKey, epoch: epoch, ready: rdy});
            fetchPcM += 32'd4;
        end
        if (redirIn) begin
            flushedM += 32'(mq.size());
            mq.delete();
            epoch++;
            fetchPcM = redirTarget;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;

        stallIn     = 1'b0;
        gntIn       = 1'b1;
        redirIn     = 1'b0;
        redirTarget = 32'h0;
        latLo       = 1;
        latHi       = 1;
        dataKey     = 32'h0;
        reset       = 1'b1;
        #2;

        // Plain streaming, 1-cycle memory returning data = address.
        doReset();
        repeat (12) applyStimulus();
        checkOutput("firstValidCyc", 32'(firstValidCyc), 32'd2);

        // Decode stalled: issue stops once the queue plus in-flight fills DEPTH.
        doReset();
        stallIn = 1'b1;
        repeat (10) applyStimulus();
        checkOutput("stallAccepts", 32'(acceptsSeen), 32'd4);
        stallIn = 1'b0;
        repeat (10) applyStimulus();

        // Redirect with two slow requests outstanding; both responses must be dropped.
        doReset();
        latLo = 4;
        latHi = 4;
        repeat (2) applyStimulus();
        redirIn     = 1'b1;
        redirTarget = 32'h100;
        applyStimulus();
        redirIn       = 1'b0;
        latLo         = 1;
        latHi         = 1;
        firstValidCyc = -1;
        repeat (12) applyStimulus();
        checkOutput("redirFirstPc", firstValidPc, 32'h100);

        // Redirect landing on a cycle with a response and a pop in progress.
        redirIn     = 1'b1;
        redirTarget = 32'h200;
        applyStimulus();
        redirIn = 1'b0;
        repeat (8) applyStimulus();

        // Random grant, latency, stall and redirects, including targets near the address wrap.
        dataKey = $urandom;
        latLo   = 1;
        latHi   = 5;
        for (int i = 0; i < 1000; i++) begin
            gntIn   = ($urandom_range(3, 0) != 0);
            stallIn = ($urandom_range(3, 0) == 0);
            redirIn = ($urandom_range(39, 0) == 0);
            redirTarget = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(3, 0) == 0)
                redirTarget = 32'hFFFF_FFF0;
            applyStimulus();
        end
        redirIn = 1'b0;

        // Reset while requests are still in flight, then resume fetching.
        doReset();
        gntIn   = 1'b1;
        stallIn = 1'b0;
        latLo   = 1;
        latHi   = 1;
        repeat (8) applyStimulus();

`ifdef IFQ_STATS_EN
        doReset();
        guard = 0;
        while (fetchedM < 32'd10 && guard < 100) begin
            applyStimulus();
            guard++;
        end
        stallIn = 1'b1;
        guard   = 0;
        while (!(mq.size() == 3 && pend.size() == 1) && guard < 50) begin
            applyStimulus();
            guard++;
        end
        checkOutput("statsSetupInTime", 32'(guard < 50), 32'd1);
        redirIn     = 1'b1;
        redirTarget = 32'h400;
        applyStimulus();
        redirIn = 1'b0;
        gntIn   = 1'b0;
        repeat (8) applyStimulus();
        checkOutput("statsFetched", fetchedCnt, 32'd10);
        checkOutput("statsFlushed", flushedCnt, 32'd4);
`else
        guard = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
